// File: rtl/fetch_seq_if.sv
// Byte-wide instruction-memory port: request/acknowledge handshake with error flag.
interface fetch_seq_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_err
    );
endinterface

// File: rtl/fetch_seq.sv
// Y86-64 sequential fetch stage: reads one instruction byte per handshake and
// splits it into icode/ifun/rA/rB/valC, producing valP and a one-cycle done pulse.
module fetch_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc_in,
    fetch_seq_if.master mem,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_done,
    output logic        instr_invalid,
    output logic        imem_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_REG,
        S_CONST,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q, addr_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  k_q, k_d;
    logic        invalid_q, invalid_d;
    logic        err_q, err_d;

    logic        fetching;
    logic        take;
    logic [3:0]  blen;

    // Instruction length in bytes from icode; undefined codes count as one byte.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:         instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:   instr_len = 4'd2;
            4'h3, 4'h4, 4'h5:         instr_len = 4'd10;
            4'h7, 4'h8:               instr_len = 4'd9;
            default:                  instr_len = 4'd1;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            icode_q   <= '0;
            ifun_q    <= '0;
            ra_q      <= '1;
            rb_q      <= '1;
            valc_q    <= '0;
            valp_q    <= '0;
            len_q     <= 4'd1;
            k_q       <= '0;
            invalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            icode_q   <= icode_d;
            ifun_q    <= ifun_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            valc_q    <= valc_d;
            valp_q    <= valp_d;
            len_q     <= len_d;
            k_q       <= k_d;
            invalid_q <= invalid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        fetching = (state_q == S_B0) || (state_q == S_REG) || (state_q == S_CONST);
        take     = fetching && mem.mem_ack;
        blen     = instr_len(mem.mem_rdata[7:4]);

        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        icode_d   = icode_q;
        ifun_d    = ifun_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        valc_d    = valc_q;
        valp_d    = valp_q;
        len_d     = len_q;
        k_d       = k_q;
        invalid_d = invalid_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_B0;
                    pc_d      = pc_in;
                    addr_d    = pc_in;
                    icode_d   = '0;
                    ifun_d    = '0;
                    ra_d      = '1;
                    rb_d      = '1;
                    valc_d    = '0;
                    k_d       = '0;
                    invalid_d = 1'b0;
                    err_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_B0, S_REG, S_CONST: begin
                if (take) begin
                    if (mem.mem_err) begin
                        // Faulting byte is dropped; valP points back at the instruction.
                        err_d   = 1'b1;
                        valp_d  = pc_q;
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 64'd1;
                        case (state_q)
                            S_B0: begin
                                icode_d   = mem.mem_rdata[7:4];
                                ifun_d    = mem.mem_rdata[3:0];
                                len_d     = blen;
                                invalid_d = mem.mem_rdata[7:4] > 4'd11;
                                if (blen == 4'd1) begin
                                    state_d = S_DONE;
                                    valp_d  = pc_q + 64'(blen);
                                end else if (blen == 4'd9) begin
                                    state_d = S_CONST;
                                end else begin
                                    state_d = S_REG;
                                end
                            end
                            S_REG: begin
                                ra_d = mem.mem_rdata[7:4];
                                rb_d = mem.mem_rdata[3:0];
                                if (len_q == 4'd10) begin
                                    state_d = S_CONST;
                                end else begin
                                    state_d = S_DONE;
                                    valp_d  = pc_q + 64'(len_q);
                                end
                            end
                            default: begin
                                valc_d[{k_q, 3'b000} +: 8] = mem.mem_rdata;
                                k_d = k_q + 3'd1;
                                if (k_q == 3'd7) begin
                                    state_d = S_DONE;
                                    valp_d  = pc_q + 64'(len_q);
                                end
                            end
                        endcase
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign mem.mem_req   = fetching;
    assign mem.mem_addr  = addr_q;
    assign icode         = icode_q;
    assign ifun          = ifun_q;
    assign rA            = ra_q;
    assign rB            = rb_q;
    assign valC          = valc_q;
    assign valP          = valp_q;
    assign instr_done    = (state_q == S_DONE);
    assign instr_invalid = invalid_q;
    assign imem_error    = err_q;
    assign busy          = fetching;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus randomized fetches
// compared against an instruction-level reference model.
module tb_fetch_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] pc_in;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_done, instr_invalid, imem_error, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_b [10];

    fetch_seq_if mif ();

    fetch_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pc_in         (pc_in),
        .mem           (mif.master),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .instr_done    (instr_done),
        .instr_invalid (instr_invalid),
        .imem_error    (imem_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_len(input int ic);
        case (ic)
            0, 1, 9:      return 1;
            2, 6, 10, 11: return 2;
            3, 4, 5:      return 10;
            7, 8:         return 9;
            default:      return 1;
        endcase
    endfunction

    // Fetch the instruction held in mem_b at address pc; waits = stall cycles
    // before each byte, err_at = byte index that faults (>= length means none).
    task automatic run_fetch(input string tag, input logic [63:0] pc, input int waits,
                             input int err_at, input bit follow_on);
        int n, stored, consumed, idx, wc, cycles, off;
        bit has_err, has_reg, took;
        logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
        logic [63:0] e_valc, e_valp;
        bit e_inv;

        n        = ref_len(int'(mem_b[0][7:4]));
        has_err  = err_at < n;
        consumed = has_err ? err_at + 1 : n;
        stored   = has_err ? err_at : n;
        has_reg  = (n == 2) || (n == 10);
        e_icode  = (stored >= 1) ? mem_b[0][7:4] : 4'h0;
        e_ifun   = (stored >= 1) ? mem_b[0][3:0] : 4'h0;
        e_ra     = (has_reg && stored >= 2) ? mem_b[1][7:4] : 4'hF;
        e_rb     = (has_reg && stored >= 2) ? mem_b[1][3:0] : 4'hF;
        e_inv    = (stored >= 1) && (mem_b[0][7:4] > 4'd11);
        e_valc   = '0;
        off      = (n == 10) ? 2 : 1;
        if (n >= 9)
            for (int j = 0; j < 8; j++)
                if (off + j < stored)
                    e_valc = e_valc + (64'(mem_b[off + j]) << (8 * j));
        e_valp   = has_err ? pc : pc + 64'(n);

        start = 1'b1;
        pc_in = pc;
        mif.mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idx = 0; wc = 0; cycles = 0;
        while (!instr_done && cycles < 200) begin
            // Noise on start/pc_in while fetching must be ignored.
            start = ($urandom_range(0, 3) == 0);
            pc_in = {$urandom, $urandom};
            if (mif.mem_req) begin
                chk({tag, ".mem_addr"}, mif.mem_addr, pc + 64'(idx));
                if (wc < waits) begin
                    mif.mem_ack   = 1'b0;
                    mif.mem_rdata = 8'($urandom);
                    mif.mem_err   = 1'($urandom);
                    wc++;
                end else begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = (idx < 10) ? mem_b[idx] : 8'h00;
                    mif.mem_err   = (idx == err_at);
                end
            end else begin
                mif.mem_ack = 1'b0;
                mif.mem_err = 1'b0;
            end
            took = mif.mem_req && mif.mem_ack;
            @(posedge clk);
            cycles++;
            if (took) begin
                idx++;
                wc = 0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mif.mem_ack = 1'b0;
        mif.mem_err = 1'b0;

        chk({tag, ".instr_done"}, 64'(instr_done), 64'd1);
        chk({tag, ".latency"}, 64'(cycles), 64'(consumed * (waits + 1)));
        chk({tag, ".bytes"}, 64'(idx), 64'(consumed));
        chk({tag, ".icode"}, 64'(icode), 64'(e_icode));
        chk({tag, ".ifun"}, 64'(ifun), 64'(e_ifun));
        chk({tag, ".rA"}, 64'(rA), 64'(e_ra));
        chk({tag, ".rB"}, 64'(rB), 64'(e_rb));
        chk({tag, ".valC"}, valC, e_valc);
        chk({tag, ".valP"}, valP, e_valp);
        chk({tag, ".instr_invalid"}, 64'(instr_invalid), 64'(e_inv));
        chk({tag, ".imem_error"}, 64'(imem_error), 64'(has_err));
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
        chk({tag, ".mem_req_done"}, 64'(mif.mem_req), 64'd0);
        if (!follow_on) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".done_pulse"}, 64'(instr_done), 64'd0);
            chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
            chk({tag, ".hold_valP"}, valP, e_valp);
            chk({tag, ".hold_icode"}, 64'(icode), 64'(e_icode));
        end
    endtask

    initial begin
        int done_seen;
        logic [63:0] pc;

        rst = 1'b1;
        start = 1'b0;
        pc_in = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        mif.mem_err = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.mem_req", 64'(mif.mem_req), 64'd0);
        chk("rst.mem_addr", mif.mem_addr, 64'd0);
        chk("rst.icode", 64'(icode), 64'd0);
        chk("rst.rA", 64'(rA), 64'hF);
        chk("rst.rB", 64'(rB), 64'hF);
        chk("rst.valC", valC, 64'd0);
        chk("rst.valP", valP, 64'd0);
        chk("rst.flags", {60'd0, instr_done, instr_invalid, imem_error, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // irmovq with zero-wait memory
        mem_b = '{8'h30, 8'hF0, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        run_fetch("irmovq", 64'h100, 0, 99, 1'b0);
        chk("irmovq.valC_abs", valC, 64'h0123456789ABCDEF);
        chk("irmovq.valP_abs", valP, 64'h10A);

        // OPq then ret back-to-back
        mem_b = '{8'h60, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_fetch("opq", 64'h200, 0, 99, 1'b1);
        mem_b[0] = 8'h90;
        run_fetch("ret", 64'h202, 0, 99, 1'b0);
        chk("ret.valP_abs", valP, 64'h203);

        // call with two stall cycles per byte
        mem_b = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_fetch("call", 64'h0, 2, 99, 1'b0);
        chk("call.valC_abs", valC, 64'h40);

        // invalid icode
        mem_b[0] = 8'hD0;
        run_fetch("invalid", 64'h20, 0, 99, 1'b0);
        chk("invalid.valP_abs", valP, 64'h21);

        // memory fault on third byte of rmmovq
        mem_b = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_fetch("memerr", 64'h50, 0, 2, 1'b0);
        chk("memerr.valP_abs", valP, 64'h50);

        // nop at the top of the address space
        mem_b[0] = 8'h10;
        run_fetch("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 0, 99, 1'b0);
        chk("wrap.valP_abs", valP, 64'h0);

        // reset while fetching byte 4 of mrmovq
        mem_b = '{8'h50, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02};
        start = 1'b1;
        pc_in = 64'h300;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mif.mem_ack = 1'b1;
            mif.mem_rdata = mem_b[i];
            @(posedge clk);
            @(negedge clk);
        end
        chk("rstmid.addr_before", mif.mem_addr, 64'h303);
        chk("rstmid.busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.mem_req", 64'(mif.mem_req), 64'd0);
        chk("rstmid.mem_addr", mif.mem_addr, 64'd0);
        chk("rstmid.icode", 64'(icode), 64'd0);
        chk("rstmid.rA", 64'(rA), 64'hF);
        chk("rstmid.valC", valC, 64'd0);
        chk("rstmid.flags", {60'd0, instr_done, instr_invalid, imem_error, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (instr_done) done_seen++;
            @(negedge clk);
        end
        chk("rstmid.no_done", 64'(done_seen), 64'd0);
        mif.mem_ack = 1'b0;

        // randomized instructions
        for (int t = 0; t < 60; t++) begin
            for (int j = 0; j < 10; j++) mem_b[j] = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                pc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 12));
            else
                pc = {$urandom, $urandom};
            run_fetch($sformatf("rand%0d", t), pc, $urandom_range(0, 2),
                      ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : 99,
                      (t != 59) && ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Sequential-processor fetch stage. Starting from a PC, it reads a Y86-64 instruction one byte at a time over a request/acknowledge instruction-memory port. It splits the bytes into icode, ifun, rA, rB and valC, and computes valP. Its outputs feed the decode stage directly; it raises a one-cycle `instr_done` pulse when the fields are stable.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: begin a fetch at `pc_in`; sampled only in IDLE or DONE.
- `pc_in` input 64: address of the instruction's first byte.
- `mem_req` output 1: byte-read request; held high until acknowledged.
- `mem_addr` output 64: byte address of the current request.
- `mem_ack` input 1: `mem_rdata`/`mem_err` are valid this cycle.
- `mem_rdata` input 8: returned byte.
- `mem_err` input 1: address fault; meaningful only when `mem_ack`=1.
- `icode` output 4: fetched instruction code.
- `ifun` output 4: fetched function code.
- `rA` output 4: register A field (F = none).
- `rB` output 4: register B field (F = none).
- `valC` output 64: constant word, little-endian.
- `valP` output 64: `pc_in` + instruction length.
- `instr_done` output 1: one-cycle pulse; the field outputs are valid.
- `instr_invalid` output 1: icode > 11 (sticky until the next `start`).
- `imem_error` output 1: `mem_err` was seen (sticky until the next `start`).
- `busy` output 1: state is not IDLE and not DONE.

## Operation
- States:
  - IDLE: wait for `start`.
  - B0: fetch the icode/ifun byte.
  - REG: fetch the register byte.
  - CONST: fetch constant bytes; 3-bit counter k runs 0..7.
  - DONE: `instr_done`=1 for exactly one cycle.
- Transitions:
  - IDLE/DONE -> B0 on `start`.
  - DONE -> IDLE otherwise.
  - Leave B0/REG/CONST only on an edge with `mem_req`&&`mem_ack`.
- `start` accepted (IDLE/DONE):
  - latch pc ← `pc_in`; `mem_addr` ← `pc_in`.
  - clear `icode`, `ifun`, `valC`, `instr_invalid`, `imem_error`; set `rA`/`rB` ← F.
  - `start` during B0/REG/CONST is ignored.
- Each byte capture: `mem_addr` ← `mem_addr`+1 (64-bit wrap at 2^64−1 → 0).
- B0 capture: `icode`←byte[7:4], `ifun`←byte[3:0]. Length N, next state:
  - 1 byte (halt 0, nop 1, ret 9) → DONE.
  - 2 bytes (cmovxx 2, OPq 6, pushq A, popq B) → REG.
  - 10 bytes (irmovq 3, rmmovq 4, mrmovq 5) → REG.
  - 9 bytes (jXX 7, call 8) → CONST.
  - icode C–F → `instr_invalid`=1, N=1, DONE.
- REG capture: `rA`←byte[7:4], `rB`←byte[3:0]; → CONST if N=10, else DONE.
- CONST capture: `valC`[8k+7:8k] ← byte; k increments; → DONE after k=7.
- `valP` = pc + N (64-bit, wraps); written on entry to DONE.
- `mem_err` with `mem_ack` in any fetch state:
  - `imem_error`=1, abort → DONE; `valP` = pc.
  - byte not stored; remaining fields keep their cleared values.
- `mem_req`=1 exactly in B0/REG/CONST.
- `mem_rdata` is ignored unless `mem_ack`=1.
- No field validity checks beyond icode (e.g. irmovq rA≠F is passed through).
- Field outputs hold their values from DONE until the next accepted `start`.

## Timing
- Reset (async, immediate): state IDLE, `mem_req`=0, `mem_addr`=0, `icode`=`ifun`=0, `rA`=`rB`=F, `valC`=0, `valP`=0, `instr_done`=`instr_invalid`=`imem_error`=`busy`=0.
- Reset mid-fetch aborts with no `instr_done`; `mem_req` drops asynchronously.
- `mem_ack` may be asserted in the same cycle `mem_req` rises (zero wait) or any number of cycles later.
- With `mem_ack` tied 1: `start` at edge 0, bytes captured at edges 1..N, `instr_done` high during the cycle after edge N. Latency is N+1 cycles.
- Back-to-back: `start` asserted during DONE makes the next edge enter B0; there are no idle cycles between instructions.
- Each wait cycle (`mem_ack`=0) adds exactly one cycle; `mem_addr` is held stable during it.

## Test plan
- irmovq at pc 0x100, `mem_ack` tied 1, bytes 30 F0 EF CD AB 89 67 45 23 01:
  - `instr_done` on cycle 11.
  - icode=3, ifun=0, rA=F, rB=0, valC=0x0123456789ABCDEF, valP=0x10A.
- OPq then ret, `start` held during DONE: bytes 60 23 then 90.
  - First done: icode=6, rA=2, rB=3, valP=pc+2.
  - Second done exactly 2 cycles later: icode=9, valP=pc+3.
- call at 0x0 (bytes 80 + 8 bytes 0x40 00..00), `mem_ack` with 2 wait cycles per byte:
  - done 28 cycles after start.
  - valC=0x40, rA=rB=F, valP=0x9.
- Byte 0xD0 at 0x20: `instr_invalid`=1, valP=0x21, done after 2 cycles.
- `mem_err` on the 3rd byte of rmmovq at 0x50: `imem_error`=1, done in the following cycle, valP=0x50, `mem_req` drops.
- pc 0xFFFF_FFFF_FFFF_FFFF with nop: valP=0.
- `rst` pulsed on byte 4 of mrmovq: outputs return to reset values immediately; no `instr_done`.
